// File: rtl/blink_driver.sv
// Turns an accepted single-cycle request into a burst of N blinks on one output line:
// each blink is ON_CYCLES high, with OFF_CYCLES low between blinks and no trailing gap.
module blink_driver #(
    parameter int ON_CYCLES  = 25000,
    parameter int OFF_CYCLES = 25000,
    parameter int BLINK_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger_i,
    input  logic [BLINK_W-1:0] count_i,
    output logic               out_o,
    output logic               busy_o,
    output logic               done_o
);

    function automatic integer clog2(input integer value);
        integer v;
        integer res;
        begin
            v   = value - 1;
            res = 0;
            while (v > 0) begin
                v   = v >> 1;
                res = res + 1;
            end
            clog2 = res;
        end
    endfunction

    localparam int MAX_PH = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int PH_W   = (clog2(MAX_PH + 1) < 1) ? 1 : clog2(MAX_PH + 1);

    // The phase counter counts down to zero; a phase of L cycles is loaded with L-1.
    localparam logic [PH_W-1:0] ON_LOAD  = PH_W'(ON_CYCLES - 1);
    localparam logic [PH_W-1:0] OFF_LOAD = PH_W'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t             state_q;
    logic [PH_W-1:0]    phase_q;
    logic [BLINK_W-1:0] remain_q;
    logic               out_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            remain_q <= '0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Requests only land here, so triggers while busy (and on the done edge) are dropped.
                    if (trigger_i && (count_i != '0)) begin
                        remain_q <= count_i;
                        phase_q  <= ON_LOAD;
                        state_q  <= S_ON;
                        out_q    <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_ON: begin
                    if (phase_q == '0) begin
                        remain_q <= remain_q - 1'b1;
                        out_q    <= 1'b0;
                        if (remain_q == BLINK_W'(1)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_OFF;
                            phase_q <= OFF_LOAD;
                        end
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                S_OFF: begin
                    if (phase_q == '0) begin
                        state_q <= S_ON;
                        phase_q <= ON_LOAD;
                        out_q   <= 1'b1;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_blink_driver.sv
// Drives two blink_driver instances (ON=4/OFF=3 and ON=2/OFF=1) with shared stimulus and
// compares every cycle against a timeline model derived from the acceptance edge.
module tb_blink_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trigger = 1'b0;
    logic [3:0] count = 4'd0;
    logic       out_a, busy_a, done_a;
    logic       out_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int   m_act [2];
    int   m_e0  [2];
    int   m_len [2];
    int   busy_n[2];
    int   rise_n[2];
    int   done_n[2];
    logic prev_out[2];

    always #5 clk = ~clk;

    blink_driver #(.ON_CYCLES(4), .OFF_CYCLES(3), .BLINK_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .trigger_i(trigger), .count_i(count),
        .out_o(out_a), .busy_o(busy_a), .done_o(done_a)
    );

    blink_driver #(.ON_CYCLES(2), .OFF_CYCLES(1), .BLINK_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .trigger_i(trigger), .count_i(count),
        .out_o(out_b), .busy_o(busy_b), .done_o(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int on_c(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int off_c(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    // Edge index j = cyc - e0 since acceptance; burst covers j = 0 .. len-1, done at j = len.
    function automatic logic exp_out(input int d);
        int j;
        j = cyc - m_e0[d];
        if (m_act[d] == 0 || j >= m_len[d]) return 1'b0;
        return ((j % (on_c(d) + off_c(d))) < on_c(d));
    endfunction

    function automatic logic exp_busy(input int d);
        return (m_act[d] != 0) && ((cyc - m_e0[d]) < m_len[d]);
    endfunction

    function automatic logic exp_done(input int d);
        return (m_act[d] != 0) && ((cyc - m_e0[d]) == m_len[d]);
    endfunction

    function automatic logic dut_out(input int d);
        return (d == 0) ? out_a : out_b;
    endfunction

    function automatic logic dut_busy(input int d);
        return (d == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic dut_done(input int d);
        return (d == 0) ? done_a : done_b;
    endfunction

    task automatic model_edge(input int d);
        logic busy_before;
        if (rst) begin
            m_act[d] = 0;
        end else begin
            busy_before = (m_act[d] != 0) && ((cyc - 1 - m_e0[d]) < m_len[d]);
            if (!busy_before && trigger && count != 4'd0) begin
                m_act[d] = 1;
                m_e0[d]  = cyc;
                m_len[d] = int'(count) * on_c(d) + (int'(count) - 1) * off_c(d);
            end
        end
    endtask

    task automatic check_cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("out[%0d]@%0d", d, cyc), 32'(dut_out(d)), 32'(exp_out(d)));
            check($sformatf("busy[%0d]@%0d", d, cyc), 32'(dut_busy(d)), 32'(exp_busy(d)));
            check($sformatf("done[%0d]@%0d", d, cyc), 32'(dut_done(d)), 32'(exp_done(d)));
            if (dut_busy(d) === 1'b1) busy_n[d]++;
            if (dut_done(d) === 1'b1) done_n[d]++;
            if (dut_out(d) === 1'b1 && prev_out[d] !== 1'b1) rise_n[d]++;
            prev_out[d] = dut_out(d);
        end
    endtask

    task automatic tick(input logic t, input logic [3:0] c);
        trigger = t;
        count   = c;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0);
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            busy_n[d] = 0;
            rise_n[d] = 0;
            done_n[d] = 0;
        end
    endtask

    task automatic check_stats(input string tag, input int d, input int bz, input int rs, input int dn);
        check({tag, "_busy_len"}, 32'(busy_n[d]), 32'(bz));
        check({tag, "_rises"}, 32'(rise_n[d]), 32'(rs));
        check({tag, "_done_pulses"}, 32'(done_n[d]), 32'(dn));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0;
            check($sformatf("async_rst_out[%0d]", d), 32'(dut_out(d)), 32'd0);
            check($sformatf("async_rst_busy[%0d]", d), 32'(dut_busy(d)), 32'd0);
            check($sformatf("async_rst_done[%0d]", d), 32'(dut_done(d)), 32'd0);
        end
        tick(1'b1, 4'd3);
        tick(1'b0, 4'd0);
        rst = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_e0[d] = 0; m_len[d] = 0; prev_out[d] = 1'b0;
        end
        clear_stats();

        #2;
        check("reset_out_a", 32'(out_a), 32'd0);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_done_a", 32'(done_a), 32'd0);
        tick(1'b1, 4'd2);
        tick(1'b0, 4'd0);
        rst = 1'b0;

        // Single blink.
        clear_stats();
        tick(1'b1, 4'd1);
        idle(10);
        check_stats("single", 0, 4, 1, 1);

        // Three blinks: 1111 000 1111 000 1111.
        clear_stats();
        tick(1'b1, 4'd3);
        idle(25);
        check_stats("triple", 0, 18, 3, 1);

        // Zero count is ignored even when held.
        clear_stats();
        for (int i = 0; i < 20; i++) tick(1'b1, 4'd0);
        check_stats("zero_cnt", 0, 0, 0, 0);
        check_stats("zero_cnt_b", 1, 0, 0, 0);

        // Retriggers mid-ON (j=2), mid-OFF (j=5) and on the done edge (j=11) are dropped.
        clear_stats();
        tick(1'b1, 4'd2);
        for (int j = 1; j <= 11; j++) tick((j == 2) || (j == 5) || (j == 11), 4'd5);
        check_stats("retrig", 0, 11, 2, 1);
        tick(1'b1, 4'd1);
        check("retrig_new_busy", 32'(busy_a), 32'd1);
        check("retrig_new_out", 32'(out_a), 32'd1);
        idle(10);

        // Asynchronous reset mid-OFF, then a clean burst.
        tick(1'b1, 4'd3);
        idle(5);
        do_reset();
        clear_stats();
        idle(25);
        check_stats("post_rst_quiet", 0, 0, 0, 0);
        clear_stats();
        tick(1'b1, 4'd1);
        idle(8);
        check_stats("post_rst", 0, 4, 1, 1);

        // Maximum count.
        clear_stats();
        tick(1'b1, 4'd15);
        idle(110);
        check_stats("max_b", 1, 44, 15, 1);
        check_stats("max_a", 0, 102, 15, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick($urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
